// File: rtl/pipe_pkg.sv
// Shared pipeline constants: payload widths and field offsets
// for each inter-stage bundle of the core.
package pipe_pkg;

   localparam int PIPE_DEF_W     = 32;
   localparam int PIPE_DEF_CNT_W = 16;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   // IF/ID: {instr, pc}
   localparam int IFID_PC_O    = 0;
   localparam int IFID_INSTR_O = IFID_PC_O + XLEN;
   localparam int IFID_W       = IFID_INSTR_O + XLEN;

   // ID/EX: {ctrl, rd, imm, rs2, rs1, pc}
   localparam int IDEX_CTRL_BITS = 8;
   localparam int IDEX_PC_O      = 0;
   localparam int IDEX_RS1_O     = IDEX_PC_O + XLEN;
   localparam int IDEX_RS2_O     = IDEX_RS1_O + XLEN;
   localparam int IDEX_IMM_O     = IDEX_RS2_O + XLEN;
   localparam int IDEX_RD_O      = IDEX_IMM_O + XLEN;
   localparam int IDEX_CTRL_O    = IDEX_RD_O + REG_AW;
   localparam int IDEX_W         = IDEX_CTRL_O + IDEX_CTRL_BITS;

   // EX/MEM: {ctrl, rd, rs2, alu}
   localparam int EXMEM_CTRL_BITS = 4;
   localparam int EXMEM_ALU_O     = 0;
   localparam int EXMEM_RS2_O     = EXMEM_ALU_O + XLEN;
   localparam int EXMEM_RD_O      = EXMEM_RS2_O + XLEN;
   localparam int EXMEM_CTRL_O    = EXMEM_RD_O + REG_AW;
   localparam int EXMEM_W         = EXMEM_CTRL_O + EXMEM_CTRL_BITS;

   // MEM/WB: {we, rd, wdata}
   localparam int MEMWB_WDATA_O = 0;
   localparam int MEMWB_RD_O    = MEMWB_WDATA_O + XLEN;
   localparam int MEMWB_WE_O    = MEMWB_RD_O + REG_AW;
   localparam int MEMWB_W       = MEMWB_WE_O + 1;

endpackage

// File: rtl/pipe_entry.sv
// One valid+data pipeline slot; clear wins over load, and
// i_zero selects whether a clear also wipes the payload.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int W = PIPE_DEF_W
) (
   input  logic         clk,
   input  logic         rset,
   input  logic         i_load,
   input  logic         i_clr,
   input  logic         i_zero,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_v;
   logic [W-1:0] r_d;

   always_ff @(posedge clk or negedge rset) begin
      if (!rset) begin
         r_v <= 1'b0;
         r_d <= '0;
      end else if (i_clr) begin
         r_v <= 1'b0;
         if (i_zero) r_d <= '0;
      end else if (i_load) begin
         r_v <= 1'b1;
         r_d <= i_data;
      end
   end

   assign o_valid = r_v;
   assign o_data  = r_d;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic stage register with valid/ready handshake, optional
// skid slot for a registered in_ready, flush and stall counter.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W      = PIPE_DEF_W,
   parameter bit SKID        = 1'b1,
   parameter bit ZERO_BUBBLE = 1'b1,
   parameter int CNT_W       = PIPE_DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_main_v;
   logic [DATA_W-1:0] w_main_d;
   logic              w_main_ld;
   logic              w_main_clr;
   logic [DATA_W-1:0] w_main_din;
   logic              w_skid_v;
   logic [DATA_W-1:0] w_skid_d;
   logic              w_skid_ld;
   logic              w_skid_clr;
   logic [CNT_W-1:0]  r_cnt;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = w_main_v & out_ready;

   pipe_entry #(
      .W (DATA_W)
   ) u_main (
      .clk     (clk),
      .rset    (rset),
      .i_load  (w_main_ld),
      .i_clr   (w_main_clr),
      .i_zero  (ZERO_BUBBLE),
      .i_data  (w_main_din),
      .o_valid (w_main_v),
      .o_data  (w_main_d)
   );

   generate
      if (SKID) begin : g_skid
         logic r_in_rdy;

         always_comb begin
            w_main_ld  = 1'b0;
            w_main_clr = 1'b0;
            w_main_din = in_data;
            w_skid_ld  = 1'b0;
            w_skid_clr = 1'b0;
            if (flush) begin
               w_main_clr = 1'b1;
               w_skid_clr = 1'b1;
            end else begin
               // in_ready is low while skid is full, so a skid
               // refill of main never collides with an accept
               if (w_out_fire && w_skid_v) begin
                  w_main_ld  = 1'b1;
                  w_main_din = w_skid_d;
                  w_skid_clr = 1'b1;
               end else if (w_in_fire) begin
                  if (!w_main_v || w_out_fire) w_main_ld = 1'b1;
                  else                         w_skid_ld = 1'b1;
               end else if (w_out_fire) begin
                  w_main_clr = 1'b1;
               end
            end
         end

         pipe_entry #(
            .W (DATA_W)
         ) u_skid (
            .clk     (clk),
            .rset    (rset),
            .i_load  (w_skid_ld),
            .i_clr   (w_skid_clr),
            .i_zero  (ZERO_BUBBLE),
            .i_data  (in_data),
            .o_valid (w_skid_v),
            .o_data  (w_skid_d)
         );

         always_ff @(posedge clk or negedge rset) begin
            if (!rset)           r_in_rdy <= 1'b1;
            else if (w_skid_clr) r_in_rdy <= 1'b1;
            else if (w_skid_ld)  r_in_rdy <= 1'b0;
         end

         assign in_ready = r_in_rdy;
      end else begin : g_single
         always_comb begin
            w_main_ld  = 1'b0;
            w_main_clr = 1'b0;
            w_main_din = in_data;
            w_skid_ld  = 1'b0;
            w_skid_clr = 1'b0;
            if (flush)               w_main_clr = 1'b1;
            else if (w_in_fire)      w_main_ld  = 1'b1;
            else if (w_out_fire)     w_main_clr = 1'b1;
         end

         assign w_skid_v = 1'b0;
         assign w_skid_d = '0;
         assign in_ready = !w_main_v | out_ready;
      end
   endgenerate

   always_ff @(posedge clk or negedge rset) begin
      if (!rset)
         r_cnt <= '0;
      else if (stall_clr)
         r_cnt <= '0;
      else if (w_main_v && !out_ready && r_cnt != CNT_MAX)
         r_cnt <= r_cnt + CNT_ONE;
   end

   assign out_valid = w_main_v;
   assign out_data  = w_main_d;
   assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: skid/zero-bubble, single-entry
// hold and narrow-counter variants with a scoreboard each.
module tb_pipe_skid_stage;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   logic rset = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic        a_fl = 0, a_iv = 0, a_ird, a_ov, a_ordy = 0, a_clr = 0;
   logic [31:0] a_id = 0, a_od;
   logic [15:0] a_cnt;
   logic        b_fl = 0, b_iv = 0, b_ird, b_ov, b_ordy = 0, b_clr = 0;
   logic [31:0] b_id = 0, b_od;
   logic [15:0] b_cnt;
   logic        c_fl = 0, c_iv = 0, c_ird, c_ov, c_ordy = 0, c_clr = 0;
   logic [31:0] c_id = 0, c_od;
   logic [3:0]  c_cnt;

   pipe_skid_stage #(.DATA_W(32), .SKID(1'b1), .ZERO_BUBBLE(1'b1),
                     .CNT_W(16)) dut_a (
      .clk(clk), .rset(rset), .flush(a_fl), .in_valid(a_iv),
      .in_ready(a_ird), .in_data(a_id), .out_valid(a_ov),
      .out_ready(a_ordy), .out_data(a_od), .stall_cnt(a_cnt),
      .stall_clr(a_clr));

   pipe_skid_stage #(.DATA_W(32), .SKID(1'b0), .ZERO_BUBBLE(1'b0),
                     .CNT_W(16)) dut_b (
      .clk(clk), .rset(rset), .flush(b_fl), .in_valid(b_iv),
      .in_ready(b_ird), .in_data(b_id), .out_valid(b_ov),
      .out_ready(b_ordy), .out_data(b_od), .stall_cnt(b_cnt),
      .stall_clr(b_clr));

   pipe_skid_stage #(.DATA_W(32), .SKID(1'b1), .ZERO_BUBBLE(1'b1),
                     .CNT_W(4)) dut_c (
      .clk(clk), .rset(rset), .flush(c_fl), .in_valid(c_iv),
      .in_ready(c_ird), .in_data(c_id), .out_valid(c_ov),
      .out_ready(c_ordy), .out_data(c_od), .stall_cnt(c_cnt),
      .stall_clr(c_clr));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   int a_pops = 0;

   always @(negedge clk or negedge rset) begin
      if (!rset) begin
         q_a.delete();
         q_b.delete();
      end else begin
         if (a_ov && a_ordy) begin
            a_pops++;
            if (q_a.size() == 0) chk("a_sb_empty", a_od, 32'hxxxx_xxxx);
            else chk("a_sb_data", a_od, q_a.pop_front());
         end
         if (a_fl) q_a.delete();
         else if (a_iv && a_ird) q_a.push_back(a_id);
         if (b_ov && b_ordy) begin
            if (q_b.size() == 0) chk("b_sb_empty", b_od, 32'hxxxx_xxxx);
            else chk("b_sb_data", b_od, q_b.pop_front());
         end
         if (b_fl) q_b.delete();
         else if (b_iv && b_ird) q_b.push_back(b_id);
      end
   end

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        clr;
      logic        eov;
      logic        eird;
      logic [31:0] eod;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin
      int p0;
      tbl[0]  = '{H, 32'hA5, H, L, L, L, H, 32'h00, 16'd0};
      tbl[1]  = '{L, 32'h00, H, L, L, H, H, 32'hA5, 16'd0};
      tbl[2]  = '{L, 32'h00, H, L, L, L, H, 32'h00, 16'd0};
      tbl[3]  = '{H, 32'h11, L, L, L, L, H, 32'h00, 16'd0};
      tbl[4]  = '{H, 32'h22, L, L, L, H, H, 32'h11, 16'd0};
      tbl[5]  = '{H, 32'h33, L, L, L, H, L, 32'h11, 16'd1};
      tbl[6]  = '{H, 32'h33, L, L, L, H, L, 32'h11, 16'd2};
      tbl[7]  = '{H, 32'h33, H, L, L, H, L, 32'h11, 16'd3};
      tbl[8]  = '{H, 32'h33, H, L, L, H, H, 32'h22, 16'd3};
      tbl[9]  = '{L, 32'h00, H, L, L, H, H, 32'h33, 16'd3};
      tbl[10] = '{L, 32'h00, H, L, L, L, H, 32'h00, 16'd3};
      tbl[11] = '{H, 32'h44, L, L, L, L, H, 32'h00, 16'd3};
      tbl[12] = '{H, 32'h55, L, L, L, H, H, 32'h44, 16'd3};
      tbl[13] = '{H, 32'h66, L, H, L, H, L, 32'h44, 16'd4};
      tbl[14] = '{L, 32'h00, H, L, L, L, H, 32'h00, 16'd5};
      tbl[15] = '{H, 32'h77, H, H, L, L, H, 32'h00, 16'd5};
      tbl[16] = '{L, 32'h00, H, L, L, L, H, 32'h00, 16'd5};
      tbl[17] = '{H, 32'h88, L, L, L, L, H, 32'h00, 16'd5};
      tbl[18] = '{L, 32'h00, H, H, L, H, H, 32'h88, 16'd5};
      tbl[19] = '{L, 32'h00, H, L, L, L, H, 32'h00, 16'd5};
      tbl[20] = '{L, 32'h00, L, L, H, L, H, 32'h00, 16'd5};
      tbl[21] = '{L, 32'h00, L, L, L, L, H, 32'h00, 16'd0};

      step();
      step();
      rset = 1'b1;

      // reset dropped while both entries are occupied
      a_iv = 1; a_id = 32'h5A; a_ordy = 0;
      step();
      a_id = 32'h5B;
      step();
      a_iv = 0;
      @(negedge clk);
      chk("a_pre_rst_ov", 32'(a_ov), 32'd1);
      chk("a_pre_rst_ird", 32'(a_ird), 32'd0);
      chk("a_pre_rst_cnt", 32'(a_cnt), 32'd1);
      #2 rset = 1'b0;
      #1;
      chk("a_rst_ov", 32'(a_ov), 32'd0);
      chk("a_rst_od", a_od, 32'd0);
      chk("a_rst_ird", 32'(a_ird), 32'd1);
      chk("a_rst_cnt", 32'(a_cnt), 32'd0);
      chk("b_rst_ird", 32'(b_ird), 32'd1);
      chk("c_rst_cnt", 32'(c_cnt), 32'd0);
      step();
      rset = 1'b1;

      for (int i = 0; i < 22; i++) begin
         a_iv = tbl[i].iv; a_id = tbl[i].d; a_ordy = tbl[i].ordy;
         a_fl = tbl[i].fl; a_clr = tbl[i].clr;
         @(negedge clk);
         chk($sformatf("a_vec%0d_ov", i), 32'(a_ov), 32'(tbl[i].eov));
         chk($sformatf("a_vec%0d_ird", i), 32'(a_ird), 32'(tbl[i].eird));
         chk($sformatf("a_vec%0d_od", i), a_od, tbl[i].eod);
         chk($sformatf("a_vec%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].ecnt));
         step();
      end
      a_iv = 0; a_fl = 0; a_clr = 0; a_ordy = 1;

      p0 = a_pops;
      for (int i = 1; i <= 16; i++) begin
         a_iv = 1; a_id = i;
         @(negedge clk);
         chk($sformatf("a_strm%0d_ird", i), 32'(a_ird), 32'd1);
         if (i > 1) chk($sformatf("a_strm%0d_ov", i), 32'(a_ov), 32'd1);
         step();
      end
      a_iv = 0;
      @(negedge clk);
      chk("a_strm_last_od", a_od, 32'h10);
      step();
      @(negedge clk);
      chk("a_strm_pops", a_pops - p0, 32'd16);
      chk("a_strm_idle_ov", 32'(a_ov), 32'd0);
      step();

      b_iv = 1; b_id = 32'hC1; b_ordy = 0;
      #1;
      chk("b_empty_ird", 32'(b_ird), 32'd1);
      chk("b_empty_ov", 32'(b_ov), 32'd0);
      step();
      b_id = 32'hC2;
      #1;
      chk("b_full_ov", 32'(b_ov), 32'd1);
      chk("b_full_od", b_od, 32'hC1);
      chk("b_full_ird_lo", 32'(b_ird), 32'd0);
      b_ordy = 1;
      #1;
      chk("b_full_ird_hi", 32'(b_ird), 32'd1);
      step();
      b_iv = 0;
      #1;
      chk("b_repl_ov", 32'(b_ov), 32'd1);
      chk("b_repl_od", b_od, 32'hC2);
      step();
      #1;
      chk("b_pop_ov", 32'(b_ov), 32'd0);
      chk("b_hold_od", b_od, 32'hC2);
      chk("b_pop_ird", 32'(b_ird), 32'd1);
      b_ordy = 0;
      step();

      c_iv = 1; c_id = 32'h1; c_ordy = 0;
      step();
      c_iv = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 10) chk("c_cnt10", 32'(c_cnt), 32'd10);
         if (n == 15) chk("c_cnt15", 32'(c_cnt), 32'd15);
      end
      chk("c_cnt_sat", 32'(c_cnt), 32'd15);
      c_clr = 1;
      step();
      c_clr = 0;
      chk("c_cnt_clr", 32'(c_cnt), 32'd0);
      step();
      chk("c_cnt_resume", 32'(c_cnt), 32'd1);
      chk("c_hold_od", c_od, 32'h1);
      c_ordy = 1;
      step();
      chk("c_drain_ov", 32'(c_ov), 32'd0);
      chk("c_drain_od", c_od, 32'd0);
      chk("c_drain_cnt", 32'(c_cnt), 32'd1);
      step();

      chk("a_sb_left", q_a.size(), 32'd0);
      chk("b_sb_left", q_b.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, an optional skid entry, flush, and bubble zeroing. It is the generalised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): each stage boundary instantiates it with a packed payload instead of hand-listing fields. Unlike a plain hold/advance register, it gives full throughput under back-pressure with a registered `in_ready`, selective flush, and a saturating stall counter for performance debug.

## Interface
- `DATA_W`, 32: payload width in bits; the whole stage bundle is packed into one vector.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `ZERO_BUBBLE`, 1: 1 = `out_data` reads 0 whenever `out_valid`=0; 0 = last payload is held.
- `CNT_W`, 16: stall counter width.

- `clk` in 1: single clock, rising edge.
- `rset` in 1: reset; asynchronous assert, active-low.
- `flush` in 1: kill all held entries at the next edge.
- `in_valid` in 1: upstream has a payload.
- `in_ready` out 1: stage accepts the payload this cycle.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: payload presented downstream.
- `out_ready` in 1: downstream accepts this cycle.
- `out_data` out DATA_W: downstream payload.
- `stall_cnt` out CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0.
- `stall_clr` in 1: synchronous clear of `stall_cnt`.

## Operation
- Transfers: `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`. Payloads leave strictly in arrival order, with no loss and no duplication.
- SKID=0: one entry `main`.
  - `in_ready` = `!main_v | out_ready`.
  - On `in_fire`, `main` takes `in_data`.
  - On `out_fire` without `in_fire`, `main_v` goes to 0.
- SKID=1: entries `main` (output side) and `skid`.
  - `in_ready` = `!skid_v`, registered.
  - `in_fire` with `main` empty or `out_fire`: `main` takes `in_data`.
  - `in_fire` with `main_v` set and no `out_fire`: `skid` takes `in_data`.
  - `out_fire` with `skid_v` set: `main` takes `skid`, and `skid_v` clears. A simultaneous `in_fire` is impossible here because `in_ready` is 0.
- Flush has the highest priority after reset:
  - All valid bits clear at the next edge.
  - Any `in_fire` in the flush cycle is discarded.
  - `out_fire` in the flush cycle still counts as delivered.
  - With ZERO_BUBBLE=1, the data registers also clear.
- ZERO_BUBBLE=1: the `main` data register is written 0 whenever `main_v` becomes 0.
- `stall_cnt` behaviour:
  - +1 per stalled cycle, saturating at 2^CNT_W−1.
  - `stall_clr` has priority over the increment.
  - Flush does not clear it.

## Timing
- Reset (async) values: `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0, all internal valid bits and data registers 0.
- Reset asserted mid-transfer drops both entries immediately. The first accept is possible in the first cycle after deassertion.
- Latency: payload accepted at edge N is on `out_data` after edge N, if `main` was empty.
- Throughput is 1 payload/cycle in both modes.
- SKID=1: no combinational path from `out_ready` to `in_ready`. `in_ready` drops in the cycle after a payload lands in `skid`, and rises in the cycle after `skid` drains.
- SKID=0: `in_ready` depends combinationally on `out_ready` (documented path).
- Simultaneous `in_fire` and `out_fire` with `main_v`=1, `skid_v`=0: `main` is replaced and `skid` stays empty.
- `flush` and `stall_clr` are sampled on the edge and take effect in the same cycle as their register updates.

## Structure
- Shared package `pipe_pkg`:
  - Per-boundary payload widths (e.g. `IDEX_W`, `EXMEM_W`) as constants.
  - Field offset constants for packing and unpacking the bundles.
  - This block itself uses no typedefs.
- Natural sub-module: `pipe_entry`, a single valid+data register with load/clear/zero controls. It is instantiated as `main`, plus `skid` when SKID=1. Control logic stays in `pipe_skid_stage`.

## Test plan
- Reset: hold `rset`=0 mid-stream, then release → `out_valid`=0, `out_data`=0, `in_ready`=1, `stall_cnt`=0; first payload 0xA5 emerges one cycle after acceptance.
- Streaming, SKID=1: 0x01..0x10 back-to-back with `out_ready`=1 → output is 0x01..0x10 in order at 1/cycle, with `in_ready` constantly 1.
- Back-pressure, SKID=1:
  - Send 0x11, 0x22, 0x33 with `out_ready`=0 → 0x11 in `main`, 0x22 in `skid`, `in_ready`=0 from the next cycle, 0x33 held upstream.
  - Raise `out_ready` → outputs are 0x11, 0x22, 0x33 in order.
  - `stall_cnt` equals the stalled cycles.
- Flush with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, `out_data`=0 (ZERO_BUBBLE=1); the flushed-cycle input never appears.
- SKID=0, ZERO_BUBBLE=0: pop without refill → `out_valid`=0 and `out_data` holds the last value; `in_ready` follows `out_ready` in the same cycle while full.
- Counter, CNT_W=4: stall for 20 cycles → `stall_cnt`=15, saturated; pulse `stall_clr` during the stall → 0, then resumes counting at 1.
